gcd_job_sequencer: RTL and testbench
====================================

Name: gcd_job_sequencer

Overview:
- Upstream front end of the GCD datapath/controller pair.
- Turns raw board inputs (operand switches, bouncy GO button) into one clean GCD job.
- Latches operands, drives go to the GCD controller and holds it until done, then captures the result and holds it for display.
- Rejects zero operands, which would never terminate the subtract loop.

Parameters:
- WIDTH, 4, operand and result width.
- DEBOUNCE_CYCLES, 16, consecutive stable samples needed to accept a button level; must be at least 2.
- TIMEOUT_CYCLES, 255, watchdog limit in WAIT state (used only with WATCHDOG_EN).

Ports:
- clk  in  1  system clock; all flops on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- btn_go  in  1  raw GO pushbutton; asynchronous and bouncy.
- sw_x  in  WIDTH  operand X switches; asynchronous, sampled only at job launch.
- sw_y  in  WIDTH  operand Y switches; same rules as sw_x.
- done_i  in  1  DONE from the GCD controller.
- gcd_i  in  WIDTH  GCD_OUT from the GCD datapath.
- x_o  out  WIDTH  latched operand X, driven to the GCD x_i.
- y_o  out  WIDTH  latched operand Y, driven to the GCD y_i.
- go_o  out  1  go to the GCD go_i.
- result_o  out  WIDTH  last captured GCD.
- result_valid  out  1  result_o holds a result from the current operands.
- busy  out  1  a job is in flight.
- err_zero  out  1  last launch was rejected because an operand was 0.
- err_timeout  out  1  watchdog abort flag (held 0 without WATCHDOG_EN).

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, FSM to IDLE, debounce counter 0, debounced level 0.
- Input conditioning:
  - btn_go passes through a 2-flop synchronizer.
  - Debouncer: a counter increments while the synced level differs from the debounced level, and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - go_press is a one-cycle pulse on the debounced rising edge only; a held button gives exactly one pulse.
- FSM states: IDLE, LOAD, START, WAIT, CAPTURE.
- IDLE:
  - On go_press: x_o<=sw_x, y_o<=sw_y, result_valid<=0, err_zero<=0, err_timeout<=0, then go to LOAD.
  - Otherwise stay.
- LOAD (1 cycle):
  - If x_o==0 or y_o==0: err_zero<=1, return to IDLE, go_o is never asserted.
  - Otherwise go to START.
- START (1 cycle): go_o<=1, busy<=1, go to WAIT.
- WAIT:
  - go_o stays high.
  - When done_i is sampled high: result_o<=gcd_i, go_o<=0, go to CAPTURE.
- CAPTURE (1 cycle): result_valid<=1, busy<=0, go to IDLE.
- Latency: from go_press to go_o high is 2 cycles. From done_i high to result_valid high is 2 cycles.
- go_press while busy, or in LOAD, START or CAPTURE, is ignored and not queued.
- done_i high while in IDLE, LOAD or START is ignored; a stale DONE from the previous job is not captured.
- x_o and y_o are stable from LOAD until the next accepted go_press. Switch changes mid-job have no effect.
- result_o holds its value until the next capture. result_valid clears on the next accepted go_press.
- Reset mid-job: immediate return to IDLE, go_o=0, all flags 0.

Optional Feature:
- Macro: WATCHDOG_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES before done_i is seen: go_o<=0, busy<=0, err_timeout<=1, result_o is unchanged, result_valid stays 0, return to IDLE.
  - done_i and the timeout in the same cycle: done_i wins.
- Undefined: no counter is built, err_timeout is tied to 0, and WAIT waits indefinitely.

Test Plan:
- Bench drives done_i/gcd_i from a behavioural GCD model that asserts done 6 cycles after go.
- Clean press, sw_x=12, sw_y=8 -> go_o high 2 cycles after the debounced edge, held until done; result_o=4, result_valid=1, busy=0.
- Bounce: btn_go toggles every 3 cycles for 40 cycles, then held high (DEBOUNCE_CYCLES=16) -> exactly one go_o assertion; x_o=12 latched.
- Zero guard, sw_x=0, sw_y=5, press -> err_zero=1, go_o stays 0, result_valid=0; the next press with x=9, y=6 gives result_o=3 and err_zero=0.
- Second press during WAIT, plus sw_x changed to 15 -> ignored; result from the original operands (x=12, y=8 -> 4); x_o is unchanged until the next accepted press.
- reset pulsed low in WAIT -> all outputs 0 asynchronously; FSM in IDLE; a later done_i pulse is not captured.
- WATCHDOG_EN, TIMEOUT_CYCLES=20, model never asserts done -> err_timeout=1 after 20 WAIT cycles, go_o=0, result_o keeps its prior value of 4.

Source files
------------

// File: rtl/gcd_job_sequencer.sv
// gcd_job_sequencer: conditions the raw GO button and switches into one clean GCD job per press,
// drives go to the GCD core until done, then holds the captured result. Optional macro: WATCHDOG_EN.
module gcd_job_sequencer #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_go,
    input  logic [WIDTH-1:0] sw_x,
    input  logic [WIDTH-1:0] sw_y,
    input  logic             done_i,
    input  logic [WIDTH-1:0] gcd_i,
    output logic [WIDTH-1:0] x_o,
    output logic [WIDTH-1:0] y_o,
    output logic             go_o,
    output logic [WIDTH-1:0] result_o,
    output logic             result_valid,
    output logic             busy,
    output logic             err_zero,
    output logic             err_timeout
);

    localparam int             DbW    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, CAPTURE} state_e;

    state_e           state_q;
    logic             sync1_q, sync2_q;
    logic [DbW-1:0]   dbCnt_q, dbCnt_d;
    logic             dbLevel_q, dbLevel_d;
    logic             goPress;
    logic [WIDTH-1:0] x_q, y_q, result_q;
    logic             go_q, resultValid_q, busy_q, errZero_q;

    if (DEBOUNCE_CYCLES < 2 || TIMEOUT_CYCLES < 1) begin : gBadParams
        $error("gcd_job_sequencer: DEBOUNCE_CYCLES must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

`ifdef WATCHDOG_EN
    localparam int             WdW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);
    logic [WdW-1:0] wdCnt_q;
    logic           errTimeout_q;
    assign err_timeout = errTimeout_q;
`else
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            dbCnt_q   <= '0;
            dbLevel_q <= 1'b0;
        end else begin
            sync1_q   <= btn_go;
            sync2_q   <= sync1_q;
            dbCnt_q   <= dbCnt_d;
            dbLevel_q <= dbLevel_d;
        end
    end

    // The level only flips after DEBOUNCE_CYCLES consecutive samples that disagree with it.
    always_comb begin
        dbCnt_d   = '0;
        dbLevel_d = dbLevel_q;
        if (sync2_q != dbLevel_q) begin
            if (dbCnt_q == DbLast) begin
                dbLevel_d = sync2_q;
            end else begin
                dbCnt_d = dbCnt_q + DbW'(1);
            end
        end
    end

    assign goPress = dbLevel_d & ~dbLevel_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            x_q           <= '0;
            y_q           <= '0;
            result_q      <= '0;
            go_q          <= 1'b0;
            resultValid_q <= 1'b0;
            busy_q        <= 1'b0;
            errZero_q     <= 1'b0;
`ifdef WATCHDOG_EN
            wdCnt_q       <= '0;
            errTimeout_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (goPress) begin
                        x_q           <= sw_x;
                        y_q           <= sw_y;
                        resultValid_q <= 1'b0;
                        errZero_q     <= 1'b0;
`ifdef WATCHDOG_EN
                        errTimeout_q  <= 1'b0;
`endif
                        state_q       <= LOAD;
                    end
                end
                // A zero operand would spin the subtract loop forever, so never launch it.
                LOAD: begin
                    if (x_q == '0 || y_q == '0) begin
                        errZero_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        state_q <= START;
                    end
                end
                START: begin
                    go_q    <= 1'b1;
                    busy_q  <= 1'b1;
`ifdef WATCHDOG_EN
                    wdCnt_q <= '0;
`endif
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (done_i) begin
                        result_q <= gcd_i;
                        go_q     <= 1'b0;
                        state_q  <= CAPTURE;
                    end
`ifdef WATCHDOG_EN
                    else if (wdCnt_q == WdLast) begin
                        go_q         <= 1'b0;
                        busy_q       <= 1'b0;
                        errTimeout_q <= 1'b1;
                        state_q      <= IDLE;
                    end else begin
                        wdCnt_q <= wdCnt_q + WdW'(1);
                    end
`endif
                end
                CAPTURE: begin
                    resultValid_q <= 1'b1;
                    busy_q        <= 1'b0;
                    state_q       <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign x_o          = x_q;
    assign y_o          = y_q;
    assign go_o         = go_q;
    assign result_o     = result_q;
    assign result_valid = resultValid_q;
    assign busy         = busy_q;
    assign err_zero     = errZero_q;

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// tb_gcd_job_sequencer: random and directed button/switch stimulus against a job-level model of the
// sequencer, with a behavioural GCD core answering go after a programmable delay.
module tb_gcd_job_sequencer;

    localparam int W   = 4;
    localparam int DEB = 16;
    localparam int TMO = 20;
`ifdef WATCHDOG_EN
    localparam bit WdOn = 1'b1;
`else
    localparam bit WdOn = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         btn_go = 1'b0;
    logic [W-1:0] sw_x = '0, sw_y = '0;
    logic         done_i;
    logic [W-1:0] gcd_i;
    logic [W-1:0] x_o, y_o, result_o;
    logic         go_o, result_valid, busy, err_zero, err_timeout;
    logic [16:0]  dutVec, modelVec;

    logic         stubDone = 1'b0, forceDone = 1'b0, stubMute = 1'b0;
    logic [W-1:0] stubGcd = '0, forceGcd = '0;
    int           stubDelay = 6, goAge = 0;

    int errorCount = 0, checkCount = 0;
    int goRises = 0, curGoLen = 0, lastGoLen = 0;
    logic goPrev = 1'b0;

    // job-level reference state
    logic         mS1, mS2, mLevel;
    int           mRun, mStage, mWaited;
    logic         mCapture;
    logic [W-1:0] mX, mY, mResult;
    logic         mGo, mValid, mBusy, mErrZero, mErrTo;

    always #5 clk = ~clk;

    assign done_i = stubDone | forceDone;
    assign gcd_i  = forceDone ? forceGcd : stubGcd;
    assign dutVec   = {x_o, y_o, go_o, result_o, result_valid, busy, err_zero, err_timeout};
    assign modelVec = {mX, mY, mGo, mResult, mValid, mBusy, mErrZero, mErrTo};

    gcd_job_sequencer #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .btn_go(btn_go), .sw_x(sw_x), .sw_y(sw_y),
        .done_i(done_i), .gcd_i(gcd_i), .x_o(x_o), .y_o(y_o), .go_o(go_o),
        .result_o(result_o), .result_valid(result_valid), .busy(busy),
        .err_zero(err_zero), .err_timeout(err_timeout)
    );

    function automatic int gcdOf(input int a, input int b);
        int t;
        while (b != 0) begin
            t = b;
            b = a % b;
            a = t;
        end
        return a;
    endfunction

    // Behavioural GCD core: raises done for one cycle stubDelay cycles after go rises.
    always @(negedge clk) begin
        if (!reset || !go_o) begin
            goAge    = 0;
            stubDone = 1'b0;
        end else begin
            goAge++;
            stubGcd  = W'(gcdOf(int'(x_o), int'(y_o)));
            stubDone = (goAge == stubDelay) && !stubMute;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic btn, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            btn_go = btn;
            sw_x   = x;
            sw_y   = y;
        end
    endtask

    task automatic pressButton(input logic [W-1:0] x, input logic [W-1:0] y);
        applyStimulus(1'b1, x, y, 24);
        applyStimulus(1'b0, x, y, 24);
    endtask

    // One clock of the reference: button history -> press, then job progress from pre-edge inputs.
    task automatic modelStep();
        logic press;
        press = 1'b0;
        if (!reset) begin
            mS1 = 0; mS2 = 0; mLevel = 0; mRun = 0; mStage = 0; mWaited = 0; mCapture = 0;
            mX = 0; mY = 0; mResult = 0; mGo = 0; mValid = 0; mBusy = 0; mErrZero = 0; mErrTo = 0;
        end else begin
            if (mS2 != mLevel) begin
                mRun++;
                if (mRun == DEB) begin
                    mLevel = mS2;
                    mRun   = 0;
                    press  = mLevel;
                end
            end else begin
                mRun = 0;
            end
            mS2 = mS1;
            mS1 = btn_go;

            if (mCapture) begin
                mValid = 1; mBusy = 0; mCapture = 0;
            end else if (mStage == 1) begin
                if (mX == 0 || mY == 0) begin
                    mErrZero = 1; mStage = 0;
                end else begin
                    mStage = 2;
                end
            end else if (mStage == 2) begin
                mGo = 1; mBusy = 1; mStage = 3; mWaited = 0;
            end else if (mStage == 3) begin
                if (done_i) begin
                    mResult = gcd_i; mGo = 0; mStage = 0; mCapture = 1;
                end else if (WdOn && mWaited + 1 == TMO) begin
                    mGo = 0; mBusy = 0; mErrTo = 1; mStage = 0;
                end else begin
                    mWaited++;
                end
            end else if (press) begin
                mX = sw_x; mY = sw_y; mValid = 0; mErrZero = 0; mErrTo = 0; mStage = 1;
            end
        end
    endtask

    always @(posedge clk) begin
        modelStep();
        #1;
        checkOutput("cycle", int'(dutVec), int'(modelVec));
        if (go_o && !goPrev) begin
            goRises++;
            curGoLen = 1;
        end else if (go_o) begin
            curGoLen++;
        end else if (goPrev) begin
            lastGoLen = curGoLen;
        end
        goPrev = go_o;
    end

    initial begin
        #300000;
        $display("[TB] FAIL globalTimeout: simulation did not finish");
        $fatal(1, "[TB] aborted");
    end

    initial begin
        int n, startRises;
        applyStimulus(1'b0, 4'd0, 4'd0, 3);
        @(posedge clk); #1;
        checkOutput("resetState", int'(dutVec), 0);
        @(negedge clk); reset = 1'b1;
        applyStimulus(1'b0, 4'd0, 4'd0, 4);

        $display("[TB] clean press 12,8");
        startRises = goRises;
        @(negedge clk); btn_go = 1'b1; sw_x = 4'd12; sw_y = 4'd8;
        n = 0;
        while (!go_o && n < 100) begin @(posedge clk); #1; n++; end
        checkOutput("pressLatency", n, 20);
        applyStimulus(1'b1, 4'd12, 4'd8, 10);
        applyStimulus(1'b0, 4'd12, 4'd8, 30);
        checkOutput("cleanResult", int'(result_o), 4);
        checkOutput("cleanValid", int'(result_valid), 1);
        checkOutput("cleanBusy", int'(busy), 0);
        checkOutput("cleanGoLen", lastGoLen, 6);
        checkOutput("cleanGoCount", goRises - startRises, 1);

        $display("[TB] bouncing button");
        startRises = goRises;
        for (int i = 0; i < 40; i++) applyStimulus(((i / 3) % 2) == 0, 4'd12, 4'd8, 1);
        applyStimulus(1'b1, 4'd12, 4'd8, 30);
        applyStimulus(1'b0, 4'd12, 4'd8, 30);
        checkOutput("bounceGoCount", goRises - startRises, 1);
        checkOutput("bounceX", int'(x_o), 12);
        checkOutput("bounceResult", int'(result_o), 4);

        $display("[TB] zero operand guard");
        startRises = goRises;
        pressButton(4'd0, 4'd5);
        checkOutput("zeroErr", int'(err_zero), 1);
        checkOutput("zeroValid", int'(result_valid), 0);
        checkOutput("zeroGoCount", goRises - startRises, 0);
        pressButton(4'd9, 4'd6);
        checkOutput("afterZeroResult", int'(result_o), 3);
        checkOutput("afterZeroErr", int'(err_zero), 0);

        $display("[TB] random operands");
        for (int k = 0; k < 6; k++) begin
            logic [W-1:0] rx, ry;
            rx = W'($urandom_range(15, 0));
            ry = W'($urandom_range(15, 0));
            for (int b = 0; b < $urandom_range(8, 0); b++)
                applyStimulus(1'($urandom_range(1, 0)), rx, ry, $urandom_range(3, 1));
            pressButton(rx, ry);
            if (rx != 0 && ry != 0)
                checkOutput("randomResult", int'(result_o), gcdOf(int'(rx), int'(ry)));
        end

`ifndef WATCHDOG_EN
        $display("[TB] second press during a long WAIT");
        stubDelay  = 70;
        startRises = goRises;
        pressButton(4'd12, 4'd8);
        applyStimulus(1'b1, 4'd15, 4'd8, 24);
        checkOutput("xHeldMidJob", int'(x_o), 12);
        checkOutput("busyMidJob", int'(busy), 1);
        applyStimulus(1'b0, 4'd15, 4'd8, 40);
        checkOutput("ignoredPressResult", int'(result_o), 4);
        checkOutput("ignoredPressX", int'(x_o), 12);
        checkOutput("ignoredPressGoCount", goRises - startRises, 1);
        stubDelay = 6;
        pressButton(4'd15, 4'd8);
        checkOutput("nextPressX", int'(x_o), 15);
        checkOutput("nextPressResult", int'(result_o), 1);
`endif

        $display("[TB] reset during WAIT");
        applyStimulus(1'b1, 4'd9, 4'd6, 1);
        n = 0;
        while (!go_o && n < 100) begin @(posedge clk); #1; n++; end
        checkOutput("goBeforeReset", int'(go_o), 1);
        @(posedge clk); #3;
        reset  = 1'b0;
        btn_go = 1'b0;
        #1;
        checkOutput("asyncReset", int'(dutVec), 0);
        applyStimulus(1'b0, 4'd9, 4'd6, 2);
        reset = 1'b1;
        @(negedge clk); forceGcd = 4'd7; forceDone = 1'b1;
        @(negedge clk); forceDone = 1'b0;
        applyStimulus(1'b0, 4'd9, 4'd6, 5);
        checkOutput("staleDoneResult", int'(result_o), 0);
        checkOutput("staleDoneValid", int'(result_valid), 0);

`ifdef WATCHDOG_EN
        $display("[TB] watchdog timeout");
        pressButton(4'd12, 4'd8);
        checkOutput("preTimeoutResult", int'(result_o), 4);
        stubMute = 1'b1;
        pressButton(4'd12, 4'd8);
        checkOutput("timeoutErr", int'(err_timeout), 1);
        checkOutput("timeoutGo", int'(go_o), 0);
        checkOutput("timeoutResult", int'(result_o), 4);
        checkOutput("timeoutValid", int'(result_valid), 0);
        checkOutput("timeoutBusy", int'(busy), 0);
        checkOutput("timeoutGoLen", lastGoLen, 20);
        stubMute = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
